bus_arbiter: RTL

Two-master, one-slave arbiter for the single-transaction memory bus driven by the CPU core. It lets a second master (DMA / boot loader) share main memory and peripherals with the CPU. It captures pulse-style requests from either master, grants the bus round-robin, and forwards exactly one outstanding transaction at a time. It routes the slave's completion pulse back to the owning master and aborts transactions the slave never answers.

---
 rtl/bus_pkg.sv | 20 ++
 rtl/bus_arbiter_if.sv | 54 +++++
 rtl/bus_req_capture.sv | 40 ++++
 rtl/bus_arbiter.sv | 115 +++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master bus arbiter.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] data;
    logic [2:0]  bhw;
    logic        write_notread;
  } bus_req_t;

  localparam logic MASTER_CPU = 1'b0;
  localparam logic MASTER_DMA = 1'b1;

endpackage

// File: rtl/bus_arbiter_if.sv
// Master request/response ports, slave-side bus and status of the arbiter.
// The slave modport is the arbiter's view; master is the environment driving it.
interface bus_arbiter_if;

  logic        i_m0_DV;
  logic [31:0] i_m0_address;
  logic [31:0] i_m0_data;
  logic [2:0]  i_m0_bhw;
  logic        i_m0_write_notread;
  logic [31:0] o_m0_data;
  logic        o_m0_DV;
  logic        o_m0_err;

  logic        i_m1_DV;
  logic [31:0] i_m1_address;
  logic [31:0] i_m1_data;
  logic [2:0]  i_m1_bhw;
  logic        i_m1_write_notread;
  logic [31:0] o_m1_data;
  logic        o_m1_DV;
  logic        o_m1_err;

  logic [31:0] o_bus_address;
  logic [31:0] o_bus_data;
  logic [2:0]  o_bus_bhw;
  logic        o_bus_write_notread;
  logic        o_bus_DV;
  logic [31:0] i_bus_data;
  logic        i_bus_DV;

  logic        o_owner;
  logic [1:0]  o_overrun;

  modport slave (
    input  i_m0_DV, i_m0_address, i_m0_data, i_m0_bhw, i_m0_write_notread,
    output o_m0_data, o_m0_DV, o_m0_err,
    input  i_m1_DV, i_m1_address, i_m1_data, i_m1_bhw, i_m1_write_notread,
    output o_m1_data, o_m1_DV, o_m1_err,
    output o_bus_address, o_bus_data, o_bus_bhw, o_bus_write_notread, o_bus_DV,
    input  i_bus_data, i_bus_DV,
    output o_owner, o_overrun
  );

  modport master (
    output i_m0_DV, i_m0_address, i_m0_data, i_m0_bhw, i_m0_write_notread,
    input  o_m0_data, o_m0_DV, o_m0_err,
    output i_m1_DV, i_m1_address, i_m1_data, i_m1_bhw, i_m1_write_notread,
    input  o_m1_data, o_m1_DV, o_m1_err,
    input  o_bus_address, o_bus_data, o_bus_bhw, o_bus_write_notread, o_bus_DV,
    output i_bus_data, i_bus_DV,
    input  o_owner, o_overrun
  );

endinterface

// File: rtl/bus_req_capture.sv
// One-deep request slot for a single master, with sticky overrun detection.
module bus_req_capture
  import bus_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     dv,
  input  bus_req_t req_in,
  input  logic     busy,
  input  logic     clr,
  output logic     want,
  output bus_req_t req,
  output logic     overrun
);

  logic pending;
  logic accept;

  assign accept = dv && !pending && !busy;
  // Bypass: a request captured this cycle already counts for arbitration.
  assign want   = pending || accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      // NOTE: the payload register is reset too, so no X can ever reach the bus outputs.
      req     <= '0;
      overrun <= 1'b0;
    end else begin
      if (accept) begin
        req     <= req_in;
        pending <= 1'b1;
      end else if (clr) begin
        pending <= 1'b0;
      end
      if (dv && !accept) overrun <= 1'b1;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter letting CPU and DMA share one single-transaction bus,
// with one outstanding transaction and a response timeout.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  bus_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT);

  state_t           state, state_nx;
  logic             owner, last_grant, pick;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       want, busy, clr, overrun;
  logic             done_ok, done_to;
  bus_req_t         in_cpu, in_dma, req_cpu, req_dma;

  bus_req_t         bus_q;
  logic             bus_dv_q;
  logic [1:0][31:0] resp_data_q;
  logic [1:0]       resp_dv_q, resp_err_q;

  assign in_cpu = '{address: bus.i_m0_address, data: bus.i_m0_data,
                    bhw: bus.i_m0_bhw, write_notread: bus.i_m0_write_notread};
  assign in_dma = '{address: bus.i_m1_address, data: bus.i_m1_data,
                    bhw: bus.i_m1_bhw, write_notread: bus.i_m1_write_notread};

  assign busy[0] = (state != IDLE)  && (owner == MASTER_CPU);
  assign busy[1] = (state != IDLE)  && (owner == MASTER_DMA);
  assign clr[0]  = (state == ISSUE) && (owner == MASTER_CPU);
  assign clr[1]  = (state == ISSUE) && (owner == MASTER_DMA);

  bus_req_capture u_cap_cpu (
    .clk(i_clk), .rst_n(i_rst_n), .dv(bus.i_m0_DV), .req_in(in_cpu),
    .busy(busy[0]), .clr(clr[0]), .want(want[0]), .req(req_cpu), .overrun(overrun[0])
  );

  bus_req_capture u_cap_dma (
    .clk(i_clk), .rst_n(i_rst_n), .dv(bus.i_m1_DV), .req_in(in_dma),
    .busy(busy[1]), .clr(clr[1]), .want(want[1]), .req(req_dma), .overrun(overrun[1])
  );

  // A response arriving on the timeout cycle still wins.
  assign done_ok = (state == WAIT) && bus.i_bus_DV;
  assign done_to = (state == WAIT) && !bus.i_bus_DV && (cnt == CNT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    // NOTE: defaults first, so no path through the case can infer a latch.
    state_nx = state;
    pick     = (want == 2'b11) ? ~last_grant : want[1];
    case (state)
      IDLE:    if (|want) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (done_ok || done_to) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owner       <= MASTER_CPU;
      last_grant  <= MASTER_DMA;
      cnt         <= '0;
      bus_q       <= '0;
      bus_dv_q    <= 1'b0;
      resp_data_q <= '0;
      resp_dv_q   <= '0;
      resp_err_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      bus_dv_q   <= 1'b0;
      resp_dv_q  <= '0;
      resp_err_q <= '0;
      cnt        <= (state == WAIT) ? cnt + 1'b1 : '0;
      if (state == IDLE && |want) begin
        owner      <= pick;
        last_grant <= pick;
      end
      if (state == ISSUE) begin
        bus_q    <= (owner == MASTER_DMA) ? req_dma : req_cpu;
        bus_dv_q <= 1'b1;
      end
      if (done_ok || done_to) begin
        resp_dv_q[owner]   <= 1'b1;
        resp_err_q[owner]  <= done_to;
        resp_data_q[owner] <= done_ok ? bus.i_bus_data : 32'h0;
      end
    end
  end

  assign bus.o_bus_address       = bus_q.address;
  assign bus.o_bus_data          = bus_q.data;
  assign bus.o_bus_bhw           = bus_q.bhw;
  assign bus.o_bus_write_notread = bus_q.write_notread;
  assign bus.o_bus_DV            = bus_dv_q;
  assign bus.o_m0_data           = resp_data_q[0];
  assign bus.o_m0_DV             = resp_dv_q[0];
  assign bus.o_m0_err            = resp_err_q[0];
  assign bus.o_m1_data           = resp_data_q[1];
  assign bus.o_m1_DV             = resp_dv_q[1];
  assign bus.o_m1_err            = resp_err_q[1];
  assign bus.o_owner             = owner;
  assign bus.o_overrun           = overrun;

endmodule
